canny_rgb_to_gray: RTL and testbench

- Avalon-ST VIP stage placed directly upstream of the Canny algorithm top.
- Converts RGB video-data packets to 8-bit luma and replicates the luma on all three symbols, so the downstream 24-bit interface is unchanged.
- Passes control and other non-video packets through bit-exact.
- Two-stage stall-all pipeline with packet-type tracking, a per-frame pixel counter and sticky protocol-error flags.

---
 rtl/canny_pkg.sv | 19 +
 rtl/canny_luma_mac.sv | 71 +++++++
 rtl/canny_rgb_to_gray.sv | 111 +++++++++++
 tb/tb_canny_rgb_to_gray.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/canny_pkg.sv
// Shared constants and types for the Canny RGB-to-gray front end: luma
// coefficients, packet-type nibbles and the packet-tracking FSM encoding.
package canny_pkg;

  localparam int unsigned KR    = 77;
  localparam int unsigned KG    = 150;
  localparam int unsigned KB    = 29;
  localparam int unsigned ROUND = 128;

  localparam logic [3:0] PKT_VIDEO = 4'h0;
  localparam logic [3:0] PKT_CTRL  = 4'hF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    VIDEO = 2'd1,
    PASS  = 2'd2
  } pkt_state_e;

endpackage

// File: rtl/canny_luma_mac.sv
// Two-stage luma datapath: stage 1 registers the weighted products, stage 2
// sums/rounds them and selects replicated luma or the raw beat.
module canny_luma_mac
  import canny_pkg::*;
#(
  parameter int DATA_W = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic              valid_i,
  input  logic              sop_i,
  input  logic              eop_i,
  input  logic              convert_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic              sop_o,
  output logic              eop_o,
  output logic [DATA_W-1:0] data_o
);

  logic [15:0]       p_r_d, p_g_d, p_b_d;
  logic [15:0]       p_r_q, p_g_q, p_b_q;
  logic [DATA_W-1:0] s1_raw_q;
  logic              s1_valid_q, s1_sop_q, s1_eop_q, s1_conv_q;
  logic [16:0]       sum;
  logic [7:0]        luma;
  logic [DATA_W-1:0] s2_data_d;

  assign p_r_d = 16'(data_i[23:16]) * 16'(KR);
  assign p_g_d = 16'(data_i[15:8])  * 16'(KG);
  assign p_b_d = 16'(data_i[7:0])   * 16'(KB);

  // Max sum is 65408, so the shifted result always fits in 8 bits.
  assign sum       = 17'(p_r_q) + 17'(p_g_q) + 17'(p_b_q) + 17'(ROUND);
  assign luma      = 8'(sum >> 8);
  assign s2_data_d = s1_conv_q ? {luma, luma, luma} : s1_raw_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge value regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q <= 1'b0;
      s1_sop_q   <= 1'b0;
      s1_eop_q   <= 1'b0;
      s1_conv_q  <= 1'b0;
      s1_raw_q   <= '0;
      p_r_q      <= '0;
      p_g_q      <= '0;
      p_b_q      <= '0;
      valid_o    <= 1'b0;
      sop_o      <= 1'b0;
      eop_o      <= 1'b0;
      data_o     <= '0;
    end else if (en_i) begin
      s1_valid_q <= valid_i;
      s1_sop_q   <= sop_i;
      s1_eop_q   <= eop_i;
      s1_conv_q  <= convert_i;
      s1_raw_q   <= data_i;
      p_r_q      <= p_r_d;
      p_g_q      <= p_g_d;
      p_b_q      <= p_b_d;
      valid_o    <= s1_valid_q;
      sop_o      <= s1_sop_q;
      eop_o      <= s1_eop_q;
      data_o     <= s2_data_d;
    end
  end

endmodule

// File: rtl/canny_rgb_to_gray.sv
// Avalon-ST stage ahead of the Canny top: converts video pixels to replicated
// luma, passes other packets raw, counts pixels and flags protocol errors.
module canny_rgb_to_gray
  import canny_pkg::*;
#(
  parameter int BITS_PER_SYMBOL  = 8,
  parameter int SYMBOLS_PER_BEAT = 3,
  localparam int DATA_W          = BITS_PER_SYMBOL * SYMBOLS_PER_BEAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bypass,
  output logic              din_ready,
  input  logic              din_valid,
  input  logic              din_sop,
  input  logic              din_eop,
  input  logic [DATA_W-1:0] din_data,
  input  logic              dout_ready,
  output logic              dout_valid,
  output logic              dout_sop,
  output logic              dout_eop,
  output logic [DATA_W-1:0] dout_data,
  output logic [31:0]       pix_count,
  output logic              err_sop,
  output logic              err_nosop
);

  pkt_state_e  state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] pix_q, pix_d;
  logic        err_sop_q, err_sop_d;
  logic        err_nosop_q, err_nosop_d;
  logic        en, accept, convert;

  // Stall-all: both stages move together whenever the output slot frees up.
  assign en        = !dout_valid || dout_ready;
  assign din_ready = en;
  assign accept    = din_valid && din_ready;
  assign convert   = (state_q == VIDEO) && !din_sop && !bypass;

  canny_luma_mac #(.DATA_W(DATA_W)) u_mac (
    .clk       (clk),
    .rst       (rst),
    .en_i      (en),
    .valid_i   (din_valid),
    .sop_i     (din_sop),
    .eop_i     (din_eop),
    .convert_i (convert),
    .data_i    (din_data),
    .valid_o   (dout_valid),
    .sop_o     (dout_sop),
    .eop_o     (dout_eop),
    .data_o    (dout_data)
  );

  // NOTE: every always_comb output gets its hold value first, so no path
  // through the branches can infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pix_d       = pix_q;
    err_sop_d   = err_sop_q;
    err_nosop_d = err_nosop_q;
    if (accept) begin
      if (din_sop) begin
        // A sop always resynchronises, even mid-packet.
        if (state_q != IDLE) err_sop_d = 1'b1;
        cnt_d = '0;
        if (din_eop)                          state_d = IDLE;
        else if (din_data[3:0] == PKT_VIDEO)  state_d = VIDEO;
        else                                  state_d = PASS;
      end else begin
        case (state_q)
          IDLE:  err_nosop_d = 1'b1;
          VIDEO: begin
            if (din_eop) begin
              pix_d   = cnt_q + 32'd1;
              cnt_d   = '0;
              state_d = IDLE;
            end else begin
              cnt_d = cnt_q + 32'd1;
            end
          end
          PASS:    if (din_eop) state_d = IDLE;
          default: state_d = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      pix_q       <= '0;
      err_sop_q   <= 1'b0;
      err_nosop_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pix_q       <= pix_d;
      err_sop_q   <= err_sop_d;
      err_nosop_q <= err_nosop_d;
    end
  end

  assign pix_count = pix_q;
  assign err_sop   = err_sop_q;
  assign err_nosop = err_nosop_q;

endmodule

// File: tb/tb_canny_rgb_to_gray.sv
// Self-checking bench for canny_rgb_to_gray: directed packet steps with random
// payloads, scored against a packet-level reference model.
module tb_canny_rgb_to_gray;
  import canny_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        bypass = 1'b0;
  logic        din_valid = 1'b0, din_sop = 1'b0, din_eop = 1'b0;
  logic [23:0] din_data = '0;
  logic        dout_ready = 1'b1;
  logic        din_ready, dout_valid, dout_sop, dout_eop;
  logic [23:0] dout_data;
  logic [31:0] pix_count;
  logic        err_sop, err_nosop;

  canny_rgb_to_gray dut (
    .clk        (clk),
    .rst        (rst),
    .bypass     (bypass),
    .din_ready  (din_ready),
    .din_valid  (din_valid),
    .din_sop    (din_sop),
    .din_eop    (din_eop),
    .din_data   (din_data),
    .dout_ready (dout_ready),
    .dout_valid (dout_valid),
    .dout_sop   (dout_sop),
    .dout_eop   (dout_eop),
    .dout_data  (dout_data),
    .pix_count  (pix_count),
    .err_sop    (err_sop),
    .err_nosop  (err_nosop)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        sop;
    logic        eop;
    logic [23:0] data;
    logic [31:0] stamp;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0, n_err = 0;
  int   cyc = 0;
  bit   lat_chk = 1'b0;
  bit   bp_on = 1'b0;

  // Reference model state: 0 = between packets, 1 = video, 2 = other packet.
  int          kind = 0;
  logic [31:0] m_cnt = 0, m_pix = 0;
  bit          m_err_sop = 0, m_err_nosop = 0;

  function automatic logic [7:0] ref_luma(input logic [23:0] d);
    int r, g, b;
    r = int'(d[23:16]);
    g = int'(d[15:8]);
    b = int'(d[7:0]);
    return 8'((77 * r + 150 * g + 29 * b + 128) / 256);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic fail_now(input string tag);
    n_vec++;
    n_err++;
    $error("FAIL %s: observed=timeout/unexpected expected=event", tag);
  endtask

  task automatic model_accept(input logic sop, input logic eop, input logic [23:0] d,
                              input logic byp);
    logic [23:0] o;
    o = d;
    if (sop) begin
      if (kind != 0) m_err_sop = 1;
      m_cnt = 0;
      if (eop)             kind = 0;
      else if (d[3:0] == 4'h0) kind = 1;
      else                 kind = 2;
    end else if (kind == 0) begin
      m_err_nosop = 1;
    end else if (kind == 1) begin
      if (!byp) o = {3{ref_luma(d)}};
      if (eop) begin
        m_pix = m_cnt + 1;
        m_cnt = 0;
        kind  = 0;
      end else begin
        m_cnt = m_cnt + 1;
      end
    end else if (eop) begin
      kind = 0;
    end
    exp_q.push_back('{sop, eop, o, 32'(cyc)});
  endtask

  task automatic model_reset();
    exp_q.delete();
    kind = 0;
    m_cnt = 0;
    m_pix = 0;
    m_err_sop = 0;
    m_err_nosop = 0;
  endtask

  task automatic send(input logic sop, input logic eop, input logic [23:0] d, input logic byp);
    bit done = 0;
    int waited = 0;
    din_valid = 1'b1;
    din_sop   = sop;
    din_eop   = eop;
    din_data  = d;
    bypass    = byp;
    while (!done) begin
      @(negedge clk);
      if (din_ready === 1'b1) begin
        model_accept(sop, eop, d, byp);
        done = 1;
      end else if (waited++ > 1000) begin
        fail_now("din_ready_wait");
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    din_valid = 1'b0;
    din_sop   = 1'b0;
    din_eop   = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while (exp_q.size() != 0 && w < 5000) begin
      @(posedge clk);
      w++;
    end
    if (exp_q.size() != 0) fail_now("drain");
    repeat (2) @(posedge clk);
    #1;
  endtask

  function automatic logic [23:0] header(input logic [3:0] typ);
    logic [23:0] h;
    h = 24'($urandom);
    h[3:0] = typ;
    return h;
  endfunction

  function automatic logic [23:0] rgb(input logic [7:0] r, input logic [7:0] g,
                                      input logic [7:0] b);
    return {r, g, b};
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    dout_ready = bp_on ? ($urandom_range(0, 99) < 30) : 1'b1;
  end

  // Output scoreboard and ready-rule check, sampled mid-cycle.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst) begin
      check("din_ready_rule", din_ready, !dout_valid || dout_ready);
      if (dout_valid && dout_ready) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_beat");
        end else begin
          e = exp_q.pop_front();
          check("dout_data", dout_data, e.data);
          check("dout_sop", dout_sop, e.sop);
          check("dout_eop", dout_eop, e.eop);
          if (lat_chk) check("latency", 64'(cyc - int'(e.stamp)), 2);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    fail_now("watchdog");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [23:0] vid_pix [5];
    vid_pix = '{rgb(8'd255, 8'd255, 8'd255), rgb(8'd255, 8'd0, 8'd0), rgb(8'd0, 8'd255, 8'd0),
                rgb(8'd0, 8'd0, 8'd255), rgb(8'd0, 8'd0, 8'd0)};

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_dout_valid", dout_valid, 0);
    check("rst_dout_sop", dout_sop, 0);
    check("rst_dout_eop", dout_eop, 0);
    check("rst_dout_data", dout_data, 0);
    check("rst_pix_count", pix_count, 0);
    check("rst_err_sop", err_sop, 0);
    check("rst_err_nosop", err_nosop, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Control packet passes raw with 2-cycle latency
    lat_chk = 1'b1;
    send(1, 0, header(PKT_CTRL), 0);
    for (int i = 0; i < 9; i++) send(0, i == 8, 24'($urandom), 0);
    drain();
    check("ctrl_pix_count", pix_count, m_pix);

    // Directed video packet
    send(1, 0, header(PKT_VIDEO), 0);
    for (int i = 0; i < 5; i++) send(0, i == 4, vid_pix[i], 0);
    drain();
    check("video_pix_count", pix_count, m_pix);

    // Bypassed video packet still counts pixels
    send(1, 0, header(PKT_VIDEO), 1);
    for (int i = 0; i < 6; i++) send(0, i == 5, 24'($urandom), 1);
    drain();
    check("bypass_pix_count", pix_count, m_pix);

    // Random backpressure over a 640-pixel packet
    lat_chk = 1'b0;
    bp_on   = 1'b1;
    send(1, 0, header(PKT_VIDEO), 0);
    for (int i = 0; i < 640; i++) send(0, i == 639, 24'($urandom), 0);
    drain();
    bp_on = 1'b0;
    check("bp_pix_count", pix_count, m_pix);
    repeat (2) @(posedge clk);
    #1;

    // Protocol errors: stray beat, then sop mid-video
    lat_chk = 1'b1;
    send(0, 0, 24'($urandom), 0);
    drain();
    check("err_nosop_set", err_nosop, m_err_nosop);
    check("err_sop_clear", err_sop, m_err_sop);
    send(1, 0, header(PKT_VIDEO), 0);
    for (int i = 0; i < 3; i++) send(0, 0, 24'($urandom), 0);
    send(1, 0, header(PKT_VIDEO), 0);
    drain();
    check("err_sop_set", err_sop, m_err_sop);
    check("resync_pix_kept", pix_count, m_pix);
    for (int i = 0; i < 2; i++) send(0, i == 1, 24'($urandom), 0);
    drain();
    check("resync_pix_count", pix_count, m_pix);

    // Asynchronous reset mid-packet
    send(1, 0, header(PKT_VIDEO), 0);
    for (int i = 0; i < 3; i++) send(0, 0, 24'($urandom), 0);
    check("pre_reset_valid", dout_valid, 1);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check("async_dout_valid", dout_valid, 0);
    check("async_dout_sop", dout_sop, 0);
    check("async_dout_eop", dout_eop, 0);
    check("async_dout_data", dout_data, 0);
    check("async_pix_count", pix_count, 0);
    check("async_err_sop", err_sop, 0);
    check("async_err_nosop", err_nosop, 0);
    #3;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Clean packet after reset
    send(1, 0, header(PKT_VIDEO), 0);
    for (int i = 0; i < 4; i++) send(0, i == 3, 24'($urandom), 0);
    drain();
    check("post_reset_pix_count", pix_count, m_pix);
    check("post_reset_err_sop", err_sop, m_err_sop);
    check("post_reset_err_nosop", err_nosop, m_err_nosop);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
